// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline stall/flush control logic.
package pipe_pkg;

  localparam int REG_W       = 4;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state sequencer for multi-cycle SRAM accesses in MEM; holds the whole
// pipeline for MEM_WAIT_CYCLES cycles, then releases it for one DONE cycle.
module mem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic stall_all
);

  // The IDLE cycle that sees mem_req is already the first stall cycle, so WAIT covers the rest.
  localparam logic [3:0] LOAD_VAL = (MEM_WAIT_CYCLES > 1) ? 4'(MEM_WAIT_CYCLES - 1) : 4'd0;

  mem_state_t state;
  mem_state_t state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    stall_all     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (MEM_WAIT_CYCLES == 1) begin
            stall_all  = 1'b1;
            state_next = DONE;
          end else if (MEM_WAIT_CYCLES > 1) begin
            stall_all     = 1'b1;
            state_next    = WAIT;
            wait_cnt_next = LOAD_VAL;
          end
        end
      end
      WAIT: begin
        stall_all     = 1'b1;
        wait_cnt_next = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Keep the stall low while reset is held, even if mem_req is asserted.
    if (rst) begin
      stall_all = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: RAW interlock, EXE branch flush and SRAM
// wait stalls, plus a performance counter of stalled cycles.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       id_src1,
  input  logic [REG_W-1:0]       id_src2,
  input  logic                   id_two_src,
  input  logic [REG_W-1:0]       exe_dest,
  input  logic                   exe_wb_en,
  input  logic [REG_W-1:0]       mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   mem_req,
  input  logic                   branch_taken,
  output logic                   freeze_front,
  output logic                   flush_if_id,
  output logic                   flush_id_exe,
  output logic                   stall_all,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic src1_hit;
  logic src2_hit;
  logic raw;

  mem_wait_fsm #(
    .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .stall_all(stall_all)
  );

  // No forwarding network: any pending writer in EXE or MEM blocks the ID read.
  assign src1_hit = ((id_src1 == exe_dest) && exe_wb_en) ||
                    ((id_src1 == mem_dest) && mem_wb_en);
  assign src2_hit = ((id_src2 == exe_dest) && exe_wb_en) ||
                    ((id_src2 == mem_dest) && mem_wb_en);
  assign raw      = src1_hit || (id_two_src && src2_hit);

  always_comb begin
    freeze_front = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    if (rst || stall_all) begin
      freeze_front = 1'b0;
    end else if (branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (raw) begin
      freeze_front = 1'b1;
      flush_id_exe = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (freeze_front || stall_all) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard vector table plus SRAM,
// collision, reset and zero-wait sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        rst0;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        mem_req;
  logic        branch_taken;
  logic        freeze_front, flush_if_id, flush_id_exe, stall_all;
  logic [15:0] stall_count;
  logic        freeze_front0, flush_if_id0, flush_id_exe0, stall_all0;
  logic [15:0] stall_count0;

  int checkCount = 0;
  int errorCount = 0;
  logic [15:0] expCount;

  typedef struct {
    string      name;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic [3:0] ed;
    logic       ew;
    logic [3:0] md;
    logic       mw;
    logic       br;
    logic       ff;
    logic       fi;
    logic       fe;
  } vec_t;

  vec_t vecs[12];
  logic sramPat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic collPat[5]  = '{1, 1, 1, 1, 0};

  pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze_front(freeze_front), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .stall_all(stall_all),
    .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze_front(freeze_front0), .flush_if_id(flush_if_id0),
    .flush_id_exe(flush_id_exe0), .stall_all(stall_all0),
    .stall_count(stall_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    mem_req = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.two;
    exe_dest = v.ed; exe_wb_en = v.ew;
    mem_dest = v.md; mem_wb_en = v.mw;
    mem_req = 1'b0; branch_taken = v.br;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compares the W=4 instance's outputs and its counter against the model count.
  task automatic checkState(input string tag, input logic ff, input logic fi,
                            input logic fe, input logic sa);
    checkOutput({tag, ".freeze_front"}, {15'd0, freeze_front}, {15'd0, ff});
    checkOutput({tag, ".flush_if_id"},  {15'd0, flush_if_id},  {15'd0, fi});
    checkOutput({tag, ".flush_id_exe"}, {15'd0, flush_id_exe}, {15'd0, fe});
    checkOutput({tag, ".stall_all"},    {15'd0, stall_all},    {15'd0, sa});
    checkOutput({tag, ".stall_count"},  stall_count,           expCount);
  endtask

  initial begin
    //          name          src1  src2  two  ed    ew  md    mw  br  ff fi fe
    vecs[0]  = '{"quiet",     4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"raw_exe",   4'd3, 4'd9, 1'b0, 4'd3, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"src2_gate", 4'd1, 4'd5, 1'b0, 4'd8, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"src2_mem",  4'd1, 4'd5, 1'b1, 4'd8, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{"br_raw",    4'd3, 4'd9, 1'b0, 4'd3, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{"br_only",   4'd2, 4'd9, 1'b0, 4'd4, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{"raw_mem",   4'd6, 4'd9, 1'b0, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"src2_exe",  4'd1, 4'd8, 1'b1, 4'd8, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"r15",       4'd15,4'd9, 1'b0, 4'd15,1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"wb_off",    4'd3, 4'd6, 1'b1, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"both_st",   4'd7, 4'd9, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{"no_match",  4'd2, 4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    clearInputs();
    rst = 1'b1;
    rst0 = 1'b1;
    expCount = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    checkState("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    #1;
    checkState("reset_gate", 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    clearInputs();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkState(vecs[i].name, vecs[i].ff, vecs[i].fi, vecs[i].fe, 1'b0);
      expCount = expCount + {15'd0, vecs[i].ff};
    end

    // Back-to-back SRAM accesses: 4 stall cycles, one DONE cycle, repeat.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clearInputs();
      mem_req = 1'b1;
      #1;
      checkState($sformatf("sram%0d", i), 1'b0, 1'b0, 1'b0, sramPat[i]);
      expCount = expCount + {15'd0, sramPat[i]};
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkState("sram_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // The branch flush is held off until the DONE cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clearInputs();
      mem_req = 1'b1;
      branch_taken = 1'b1;
      #1;
      checkState($sformatf("coll%0d", i), 1'b0, !collPat[i], !collPat[i], collPat[i]);
      expCount = expCount + {15'd0, collPat[i]};
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkState("coll_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted during the second stall cycle of an access.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clearInputs();
      mem_req = 1'b1;
      #1;
      checkState($sformatf("rst_wait%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      expCount = expCount + 16'd1;
    end
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    rst = 1'b1;
    expCount = 16'd0;
    #1;
    checkState("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    #1;
    checkState("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clearInputs();
      mem_req = 1'b1;
      #1;
      checkState($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, collPat[i]);
      expCount = expCount + {15'd0, collPat[i]};
    end

    // Zero-wait instance: mem_req never stalls, so a RAW hazard still freezes.
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    rst0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clearInputs();
      mem_req = 1'b1;
      if (i == 5) begin
        id_src1 = 4'd4; exe_dest = 4'd4; exe_wb_en = 1'b1;
      end
      #1;
      checkOutput($sformatf("w0_stall%0d", i), {15'd0, stall_all0}, 16'd0);
      checkOutput($sformatf("w0_freeze%0d", i), {15'd0, freeze_front0}, {15'd0, i == 5});
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("w0_count", stall_count0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage ARM pipeline. It drives the freeze and flush inputs of the PC, IF/ID and ID/EXE pipeline registers. It handles three things: RAW hazards (the pipeline has no forwarding), taken branches resolved in EXE, and multi-cycle SRAM accesses in the MEM stage. A small wait-state FSM tracks SRAM accesses, and a free-running counter records stall cycles for performance measurement.

## Interface
- MEM_WAIT_CYCLES, default 4: number of cycles the whole pipeline stalls per SRAM access; valid range 0–15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_src1  in  4  Rn of the instruction in ID.
- id_src2  in  4  Rm/Rd of the instruction in ID (second read port).
- id_two_src  in  1  instruction in ID reads id_src2; this is (~I | mem_write).
- exe_dest  in  4  destination register of the instruction in EXE.
- exe_wb_en  in  1  instruction in EXE writes back.
- mem_dest  in  4  destination register of the instruction in MEM.
- mem_wb_en  in  1  instruction in MEM writes back.
- mem_req  in  1  instruction in MEM performs a load or store.
- branch_taken  in  1  branch resolved taken in EXE this cycle.
- freeze_front  out  1  PC and IF/ID hold their values.
- flush_if_id  out  1  IF/ID loads a bubble.
- flush_id_exe  out  1  ID/EXE loads a bubble.
- stall_all  out  1  PC and every pipeline register hold their values; SRAM access in progress.
- stall_count  out  16  cumulative count of cycles in which freeze_front or stall_all was high.

## Operation
- The three stall/flush outputs below are combinational from the current state and inputs. They are sampled by the pipeline registers at the next rising edge.
- **RAW hazard:** raw = (id_src1==exe_dest & exe_wb_en) | (id_src1==mem_dest & mem_wb_en) | id_two_src & ((id_src2==exe_dest & exe_wb_en) | (id_src2==mem_dest & mem_wb_en)).
  - R15 gets no special treatment.
- **Priority, highest first:**
  1. stall_all. When high, freeze_front, flush_if_id and flush_id_exe are all 0.
  2. branch_taken. Drives flush_if_id=1 and flush_id_exe=1 with freeze_front=0; the instruction in ID is squashed, so raw is ignored.
  3. raw. Drives freeze_front=1 and flush_id_exe=1, inserting a bubble into EXE.
  4. Otherwise all outputs are 0.
- **Memory FSM states:** IDLE, WAIT, DONE. The 4-bit counter is wait_cnt.
  - IDLE, mem_req=1:
    - MEM_WAIT_CYCLES==0: stall_all=0 and the FSM stays in IDLE.
    - MEM_WAIT_CYCLES==1: stall_all=1 and the next state is DONE.
    - Otherwise: stall_all=1, the next state is WAIT, and wait_cnt is loaded with MEM_WAIT_CYCLES-1.
  - IDLE, mem_req=0: stall_all=0 and the FSM stays in IDLE.
  - WAIT: stall_all=1 and wait_cnt decrements each cycle. When wait_cnt==1, the next state is DONE.
  - DONE: stall_all=0 for exactly one cycle, regardless of mem_req; the pipeline advances and the load result is captured. The next state is IDLE.
  - A new mem_req arriving back-to-back (first visible in IDLE after DONE) starts a fresh access.
- **stall_count:** increments by 1 in each cycle where freeze_front | stall_all. It wraps from 0xFFFF to 0x0000.

## Timing
- Each SRAM access with MEM_WAIT_CYCLES=W≥1 stalls for exactly W cycles. The memory instruction occupies MEM for W+1 cycles.
- Hazard and branch outputs have zero latency: same cycle as the causing inputs.
- A load-use or ALU-use dependency on EXE costs 2 bubbles; a dependency on MEM costs 1 bubble.
- Simultaneous events:
  - mem_req with branch_taken: stall_all wins. The branch flush is issued in the DONE cycle, because branch_taken is still held by the frozen EXE stage.
  - branch_taken with raw: flush only, no freeze.
- Reset:
  - The FSM state, wait_cnt and stall_count are asynchronously cleared to IDLE, 0 and 0.
  - While rst is high, all outputs are 0.
  - Reset mid-WAIT abandons the access and returns to IDLE immediately.

## Structure
- The shared package pipe_pkg holds:
  - the mem_state_t enum (IDLE, WAIT, DONE);
  - the constant REG_W=4;
  - the constant STALL_CNT_W=16.
- Sub-module mem_wait_fsm (ports: clk, rst, mem_req, stall_all) contains the FSM and wait_cnt.
- Hazard comparison, output priority and stall_count live in the top level.

## Test plan
- **RAW on EXE:** id_src1=3, exe_dest=3, exe_wb_en=1, other stages clear -> freeze_front=1, flush_id_exe=1, flush_if_id=0; stall_count increments by 1.
- **Two-source gating:** id_src2=5, mem_dest=5, mem_wb_en=1. With id_two_src=0 -> all outputs 0. With id_two_src=1 -> freeze_front=1 and flush_id_exe=1.
- **Branch over hazard:** branch_taken=1 together with a raw match -> flush_if_id=1, flush_id_exe=1, freeze_front=0.
- **SRAM wait, W=4:** mem_req held high -> stall_all=1 for exactly 4 cycles, then 0 for 1 cycle (DONE). If mem_req is still high, stall_all goes high again on the next cycle; stall_count rises by 4 per access.
- **Collision:** mem_req and branch_taken both asserted -> flush outputs stay 0 during the stall and assert in the DONE cycle.
- **Reset mid-WAIT and W=0:**
  - Assert rst in the 2nd stall cycle -> stall_all=0 immediately, stall_count=0, FSM in IDLE.
  - Rebuild with MEM_WAIT_CYCLES=0 and drive mem_req=1 -> stall_all never asserts.
